ppu_tile_fetch_engine: RTL
==========================

# ppu_tile_fetch_engine

Parametrised successor to the PPU per-tile VRAM fetch FSM. For each 8-pixel tile slot it fetches from VRAM:
- the background nametable, attribute and pattern bytes;
- pattern rows for up to NUM_SPRITES sprites, applying flip and X-alignment;
- a configurable read latency.

It presents one fully assembled tile record on a valid/ready output towards the 8-pixel renderer. A one-deep output slot lets the next tile's fetch overlap with a stalled consumer.

## Interface
- NUM_SPRITES, 2: sprite channels per tile, 1..8
- VRAM_LAT, 1: cycles from vram_rd_en to valid vram_data_in, 1..4
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  fetch request; accepted only when busy=0
- busy  out  1  high from accepted start until the record is written to the output slot
- curr_row, curr_col  in  9 each  screen position of tile slot; curr_col is signed (negative = prefetch left of screen)
- ppu_ctrl1, ppu_ctrl2  in  8 each  [5] of ctrl1 = 8x16 sprites; [4] of ctrl2 = sprite enable
- nametable_ptr, attr_ptr  in  16 each  background byte addresses
- pattern_table_offset  in  3  fine Y within the tile
- attr_shift  in  2  selects 2-bit quadrant of the attribute byte
- background_pattern_base, sprite_pattern_base  in  16 each
- sprite_on_tile  in  NUM_SPRITES  per-sprite hit on this tile row
- sprite_tile_num, sprite_row, sprite_col, sprite_attr  in  8*NUM_SPRITES each  packed; channel i is at [8i+7:8i]
- vram_addr  out  16  read address
- vram_rd_en  out  1  read strobe
- vram_data_in  in  8  read data
- out_valid  out  1  output record valid
- out_ready  in  1  consumer accepts the record
- out_row, out_col  out  9 each  tile screen position
- out_bg_lo, out_bg_hi  out  8 each  background pattern planes
- out_bg_attr  out  2  palette select
- out_spr_lo, out_spr_hi  out  8*NUM_SPRITES each  aligned sprite planes; 0 = transparent
- out_spr_attr  out  8*NUM_SPRITES  pass-through attributes
- out_spr_mask  out  NUM_SPRITES  sprite channels actually fetched

## Operation
- On start acceptance, every input except out_ready and vram_data_in is latched into a job register; later input changes have no effect on the job.
- States: IDLE → NT → AT → PT_LO → PT_HI → SPR_SCAN → SPR_LO → SPR_HI → (back to SPR_SCAN) → PUSH → IDLE.
- Each fetch state:
  - Cycle 0: drive vram_addr and assert vram_rd_en for exactly one cycle.
  - Count VRAM_LAT cycles with lat_cnt.
  - Capture vram_data_in on the cycle where lat_cnt reaches VRAM_LAT.
- Background addresses:
  - NT reads nametable_ptr; AT reads attr_ptr.
  - PT_LO reads background_pattern_base + {nt,4'b0} + pattern_table_offset; PT_HI reads that address + 8. All sums are mod 2^16.
  - bg_attr = attr_byte[2*attr_shift +: 2].
- SPR_SCAN:
  - Takes one cycle per channel index i, from 0 to NUM_SPRITES-1.
  - A channel is active when sprite_on_tile[i] & ppu_ctrl2[4]. Active channels go to SPR_LO; inactive channels are zeroed and skipped.
  - After the last index, go to PUSH.
- Sprite row offset: dy = curr_row − sprite_row, kept to 4 bits.
  - 8x8 mode: r = attr[7] ? 7−dy[2:0] : dy[2:0]; address = sprite_pattern_base + {tile,4'b0} + r.
  - 8x16 mode: r = attr[7] ? 15−dy : dy; address = (tile[0] ? 16'h1000 : 0) + {tile[7:1],5'b0} + {r[3],4'b0} + r[2:0].
  - SPR_HI reads the SPR_LO address + 8.
- Sprite alignment on capture:
  - If attr[6] is set, bit-reverse the plane.
  - d = signed curr_col − sprite_col (10-bit). If d ≥ 0 the plane is shifted left by d, otherwise right by −d. Any |d| ≥ 8 gives 0.
- PUSH: wait until the output slot is free (out_valid=0, or out_valid & out_ready in the same cycle). Then load the slot, set out_valid=1 and go to IDLE with busy=0.
- The output slot holds its contents stable while out_valid & !out_ready.
- Reset values:
  - All outputs 0, state IDLE, job register 0.
  - A reset during an operation aborts the job. The read that was in flight is discarded.

## Timing
- Fetch latency: k active sprites take (4+2k)(VRAM_LAT+1) fetch cycles, plus NUM_SPRITES scan cycles, plus 1 PUSH cycle. out_valid rises on the cycle after PUSH.
- Example: NUM_SPRITES=2, VRAM_LAT=1, k=0 → 8+2+1 = 11 cycles from the start edge.
- Back-to-back: start may be accepted the cycle after busy falls, even while out_valid is still held. The next job stalls in PUSH until the slot drains.
- start while busy=1 is ignored; it is not queued.
- vram_rd_en is never high for two consecutive cycles when VRAM_LAT ≥ 1.

## Structure
- Package ppu_fetch_pkg contains:
  - the state enum;
  - SPR16_BIT=5, SPR_EN_BIT=4, SPR_BANK1=16'h1000;
  - the VRAM_LAT range limits.
- Sub-module ppu_sprite_xform is combinational: it takes a plane, attr, curr_col and sprite_col and returns the aligned plane. It is instantiated once and shared across channels by the SPR_HI/SPR_LO capture mux.

## Test plan
- Background only, VRAM_LAT=1, nt=0x24, base=0x1000, offset=3 → reads 0x2xxx, attr, 0x1243, 0x124B. out_valid at cycle 11 with correct planes and bg_attr from attr_shift=2 (bits [5:4]).
- Sprite 0 at col 0x10, curr_col 0x12, plane 0xF0, hflip → aligned plane = 0x0F<<2 = 0x3C. mask=01. Channel 1 zero.
- 8x16, tile 0x05, vflip, dy=3 → address 0x1000+0x040+0x10+4 = 0x1054, HI = 0x105C.
- out_ready low for 20 cycles with a second start → second job is held in PUSH, busy=1, and the first record stays stable. When ready rises, records appear in order.
- VRAM_LAT=3, ppu_ctrl2[4]=0 with all sprite_on_tile set → no sprite reads, mask=0, latency 16+NUM_SPRITES+1.
- rst low during SPR_LO → all outputs 0 next cycle. After release, a new start completes normally.

Source files
------------

// File: rtl/ppu_fetch_pkg.sv
// Shared types and constants for the PPU tile fetch engine.
// Holds the fetch FSM state encoding and control-bit positions.
package ppu_fetch_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_NT,
        S_AT,
        S_PT_LO,
        S_PT_HI,
        S_SPR_SCAN,
        S_SPR_LO,
        S_SPR_HI,
        S_PUSH
    } fetch_state_e;

    localparam int          SPR16_BIT    = 5;
    localparam int          SPR_EN_BIT   = 4;
    localparam logic [15:0] SPR_BANK1    = 16'h1000;
    localparam int          VRAM_LAT_MIN = 1;
    localparam int          VRAM_LAT_MAX = 4;

    function automatic logic [1:0] attr_quad(
        input logic [7:0] attr_byte,
        input logic [1:0] shift
    );
        logic [1:0] q;
        unique case (shift)
            2'd0: q = attr_byte[1:0];
            2'd1: q = attr_byte[3:2];
            2'd2: q = attr_byte[5:4];
            2'd3: q = attr_byte[7:6];
            default: q = 2'd0;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/ppu_sprite_xform.sv
// Sprite plane alignment: optional horizontal flip, then shift
// by the signed distance between tile column and sprite column.
module ppu_sprite_xform (
    input  logic [7:0] plane,
    input  logic [7:0] attr,
    input  logic [8:0] curr_col,
    input  logic [7:0] sprite_col,
    output logic [7:0] aligned
);

    logic [7:0]        src;
    logic signed [9:0] d;
    logic [9:0]        mag;
    logic              unused_attr;

    assign unused_attr = ^{attr[7], attr[5:0]};

    always_comb begin
        src = plane;
        if (attr[6]) begin
            for (int b = 0; b < 8; b++) begin
                src[b] = plane[7-b];
            end
        end
        d   = $signed({curr_col[8], curr_col}) - $signed({2'b00, sprite_col});
        mag = d[9] ? 10'(-d) : 10'(d);
        aligned = 8'h00;
        if (mag < 10'd8) begin
            aligned = d[9] ? (src >> mag[2:0]) : (src << mag[2:0]);
        end
    end

endmodule

// File: rtl/ppu_tile_fetch_engine.sv
// Per-tile VRAM fetch FSM: background bytes, sprite rows, and a
// one-deep valid/ready output slot towards the pixel renderer.
module ppu_tile_fetch_engine
    import ppu_fetch_pkg::*;
#(
    parameter int NUM_SPRITES = 2,
    parameter int VRAM_LAT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    input  logic [8:0]               curr_row,
    input  logic [8:0]               curr_col,
    input  logic [7:0]               ppu_ctrl1,
    input  logic [7:0]               ppu_ctrl2,
    input  logic [15:0]              nametable_ptr,
    input  logic [15:0]              attr_ptr,
    input  logic [2:0]               pattern_table_offset,
    input  logic [1:0]               attr_shift,
    input  logic [15:0]              background_pattern_base,
    input  logic [15:0]              sprite_pattern_base,
    input  logic [NUM_SPRITES-1:0]   sprite_on_tile,
    input  logic [8*NUM_SPRITES-1:0] sprite_tile_num,
    input  logic [8*NUM_SPRITES-1:0] sprite_row,
    input  logic [8*NUM_SPRITES-1:0] sprite_col,
    input  logic [8*NUM_SPRITES-1:0] sprite_attr,
    output logic [15:0]              vram_addr,
    output logic                     vram_rd_en,
    input  logic [7:0]               vram_data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [8:0]               out_row,
    output logic [8:0]               out_col,
    output logic [7:0]               out_bg_lo,
    output logic [7:0]               out_bg_hi,
    output logic [1:0]               out_bg_attr,
    output logic [8*NUM_SPRITES-1:0] out_spr_lo,
    output logic [8*NUM_SPRITES-1:0] out_spr_hi,
    output logic [8*NUM_SPRITES-1:0] out_spr_attr,
    output logic [NUM_SPRITES-1:0]   out_spr_mask
);

    localparam int             IW   = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [IW-1:0]  LAST = IW'(NUM_SPRITES - 1);
    localparam logic [2:0]     LAT  = 3'(VRAM_LAT);

    fetch_state_e state, state_nxt;
    logic [2:0]    lat_cnt;
    logic [IW-1:0] idx;

    logic [8:0]  j_row, j_col;
    logic        j_spr16, j_spr_en;
    logic [15:0] j_nt_ptr, j_at_ptr, j_bg_base, j_spr_base;
    logic [2:0]  j_fine_y;
    logic [1:0]  j_attr_shift;
    logic [NUM_SPRITES-1:0] j_on;
    logic [7:0]  j_tile [NUM_SPRITES];
    logic [7:0]  j_srow [NUM_SPRITES];
    logic [7:0]  j_scol [NUM_SPRITES];
    logic [7:0]  j_sattr[NUM_SPRITES];

    logic [7:0]  nt_byte, bg_lo, bg_hi;
    logic [1:0]  bg_attr;
    logic [7:0]  spr_lo [NUM_SPRITES];
    logic [7:0]  spr_hi [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] spr_mask;

    logic        accept, lat_done, slot_free, push, is_fetch, active;
    logic [15:0] pt_addr, spr_addr;
    logic [7:0]  sel_tile, sel_attr, sel_row, aligned;
    logic [3:0]  dy, r16;
    logic [2:0]  r8;
    logic        unused_ctrl;

    assign unused_ctrl = ^{ppu_ctrl1[7:6], ppu_ctrl1[4:0],
                           ppu_ctrl2[7:5], ppu_ctrl2[3:0]};

    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) & start;
    assign lat_done  = (lat_cnt == LAT);
    assign slot_free = !out_valid | out_ready;
    assign is_fetch  = state inside {S_NT, S_AT, S_PT_LO, S_PT_HI,
                                     S_SPR_LO, S_SPR_HI};
    assign active    = j_on[idx] & j_spr_en;

    assign pt_addr = j_bg_base + {4'b0, nt_byte, 4'b0}
                   + {13'b0, j_fine_y};

    always_comb begin
        sel_tile = j_tile[idx];
        sel_attr = j_sattr[idx];
        sel_row  = j_srow[idx];
        dy  = 4'(j_row - {1'b0, sel_row});
        r16 = sel_attr[7] ? 4'd15 - dy : dy;
        r8  = sel_attr[7] ? 3'd7 - dy[2:0] : dy[2:0];
        if (j_spr16) begin
            spr_addr = (sel_tile[0] ? SPR_BANK1 : 16'h0000)
                     + {4'b0, sel_tile[7:1], 5'b0}
                     + {11'b0, r16[3], 4'b0}
                     + {13'b0, r16[2:0]};
        end else begin
            spr_addr = j_spr_base + {4'b0, sel_tile, 4'b0}
                     + {13'b0, r8};
        end
    end

    ppu_sprite_xform u_xform (
        .plane      (vram_data_in),
        .attr       (sel_attr),
        .curr_col   (j_col),
        .sprite_col (j_scol[idx]),
        .aligned    (aligned)
    );

    always_comb begin
        state_nxt = state;
        vram_addr = 16'h0000;
        push      = 1'b0;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_NT;
            S_NT: begin
                vram_addr = j_nt_ptr;
                if (lat_done) state_nxt = S_AT;
            end
            S_AT: begin
                vram_addr = j_at_ptr;
                if (lat_done) state_nxt = S_PT_LO;
            end
            S_PT_LO: begin
                vram_addr = pt_addr;
                if (lat_done) state_nxt = S_PT_HI;
            end
            S_PT_HI: begin
                vram_addr = pt_addr + 16'd8;
                if (lat_done) state_nxt = S_SPR_SCAN;
            end
            S_SPR_SCAN: begin
                if (active) state_nxt = S_SPR_LO;
                else if (idx == LAST) state_nxt = S_PUSH;
            end
            S_SPR_LO: begin
                vram_addr = spr_addr;
                if (lat_done) state_nxt = S_SPR_HI;
            end
            S_SPR_HI: begin
                vram_addr = spr_addr + 16'd8;
                if (lat_done) begin
                    state_nxt = (idx == LAST) ? S_PUSH : S_SPR_SCAN;
                end
            end
            S_PUSH: begin
                if (slot_free) begin
                    push      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        vram_rd_en = is_fetch & (lat_cnt == 3'd0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            lat_cnt <= 3'd0;
            idx     <= '0;
        end else begin
            state <= state_nxt;
            if (is_fetch && !lat_done) lat_cnt <= lat_cnt + 3'd1;
            else lat_cnt <= 3'd0;
            if (accept) begin
                idx <= '0;
            end else if (idx != LAST) begin
                if ((state == S_SPR_SCAN && !active) ||
                    (state == S_SPR_HI && lat_done)) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            j_row <= '0; j_col <= '0;
            j_spr16 <= 1'b0; j_spr_en <= 1'b0;
            j_nt_ptr <= '0; j_at_ptr <= '0;
            j_bg_base <= '0; j_spr_base <= '0;
            j_fine_y <= '0; j_attr_shift <= '0;
            j_on <= '0;
            nt_byte <= '0; bg_lo <= '0; bg_hi <= '0; bg_attr <= '0;
            spr_mask <= '0;
            out_valid <= 1'b0;
            out_row <= '0; out_col <= '0;
            out_bg_lo <= '0; out_bg_hi <= '0; out_bg_attr <= '0;
            out_spr_lo <= '0; out_spr_hi <= '0;
            out_spr_attr <= '0; out_spr_mask <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                j_tile[i] <= '0; j_srow[i] <= '0;
                j_scol[i] <= '0; j_sattr[i] <= '0;
                spr_lo[i] <= '0; spr_hi[i] <= '0;
            end
        end else begin
            if (accept) begin
                j_row        <= curr_row;
                j_col        <= curr_col;
                j_spr16      <= ppu_ctrl1[SPR16_BIT];
                j_spr_en     <= ppu_ctrl2[SPR_EN_BIT];
                j_nt_ptr     <= nametable_ptr;
                j_at_ptr     <= attr_ptr;
                j_bg_base    <= background_pattern_base;
                j_spr_base   <= sprite_pattern_base;
                j_fine_y     <= pattern_table_offset;
                j_attr_shift <= attr_shift;
                j_on         <= sprite_on_tile;
                spr_mask     <= '0;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    j_tile[i]  <= sprite_tile_num[8*i +: 8];
                    j_srow[i]  <= sprite_row[8*i +: 8];
                    j_scol[i]  <= sprite_col[8*i +: 8];
                    j_sattr[i] <= sprite_attr[8*i +: 8];
                end
            end
            if (lat_done) begin
                unique case (state)
                    S_NT:     nt_byte <= vram_data_in;
                    S_AT:     bg_attr <= attr_quad(vram_data_in, j_attr_shift);
                    S_PT_LO:  bg_lo   <= vram_data_in;
                    S_PT_HI:  bg_hi   <= vram_data_in;
                    S_SPR_LO: spr_lo[idx] <= aligned;
                    S_SPR_HI: begin
                        spr_hi[idx]   <= aligned;
                        spr_mask[idx] <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (state == S_SPR_SCAN && !active) begin
                spr_lo[idx]   <= 8'h00;
                spr_hi[idx]   <= 8'h00;
                spr_mask[idx] <= 1'b0;
            end
            // Loading and draining in the same cycle keeps the slot full.
            if (push) begin
                out_valid    <= 1'b1;
                out_row      <= j_row;
                out_col      <= j_col;
                out_bg_lo    <= bg_lo;
                out_bg_hi    <= bg_hi;
                out_bg_attr  <= bg_attr;
                out_spr_mask <= spr_mask;
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    out_spr_lo[8*i +: 8]   <= spr_lo[i];
                    out_spr_hi[8*i +: 8]   <= spr_hi[i];
                    out_spr_attr[8*i +: 8] <= j_sattr[i];
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
